// File: rtl/seq_add_sub_pkg.sv
// Shared definitions for the slice-serial adder/subtractor: FSM encoding and
// helpers that size the slice counter from the operand and slice widths.
package seq_add_sub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // A single-slice configuration still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// One CHUNK-bit adder slice. Also exposes the carry into the top bit so the
// caller can form signed overflow on the most-significant slice.
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign s     = full[CHUNK-1:0];
    assign co    = full[CHUNK];
    // The top sum bit is a ^ b ^ carry-in, so the carry-in falls out directly.
    assign c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/seq_add_sub.sv
// Slice-serial adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// with the inter-slice carry held in a register and valid/ready on both sides.
module seq_add_sub
    import seq_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int unsigned CntW   = cnt_width(NCHUNK);
    localparam logic [CntW-1:0] LastCnt = CntW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("seq_add_sub: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0]       slice_s;
    logic                   slice_co;
    logic                   slice_c_msb;
    logic [WIDTH+CHUNK-1:0] sum_shift;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .ci    (carry_q),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    // New slice enters at the top; after NCHUNK shifts slice 0 sits at the bottom.
    assign sum_shift = {slice_s, sum_q};

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = sum_shift[WIDTH+CHUNK-1:CHUNK];
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    carry_out_d = slice_co;
                    overflow_d  = slice_c_msb ^ slice_co;
                    zero_d      = (sum_d == '0);
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed bench for seq_add_sub: a 4-slice instance and a single-slice
// instance driven by the same stimulus, checked against hand-computed results.
module tb_seq_add_sub;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_ready;

    logic        in_ready,   in_ready_w;
    logic        out_valid,  out_valid_w;
    logic [31:0] sum,        sum_w;
    logic        carry_out,  carry_out_w;
    logic        overflow,   overflow_w;
    logic        zero,       zero_w;

    int    n_cmp = 0;
    int    n_err = 0;
    string cur   = "init";

    seq_add_sub #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    seq_add_sub #(
        .WIDTH (32),
        .CHUNK (32)
    ) dut_w (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .sum       (sum_w),
        .carry_out (carry_out_w),
        .overflow  (overflow_w),
        .zero      (zero_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur, tag, obs, exp);
        end
    endtask

    // Issue one operation to both instances, check latency and results, optionally
    // stall in DONE for `hold` cycles with fresh operands offered, then hand off.
    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic [31:0] es, input logic eco,
                          input logic eov, input logic ez, input int hold);
        int lat;
        int lat_w;
        cur = name;
        check_eq("in_ready_pre", {63'd0, in_ready}, 64'd1);
        a        = ta;
        b        = tb_v;
        sub      = ts;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~ta;
        b        = $urandom;
        sub      = ~ts;
        lat      = -1;
        lat_w    = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (out_valid && lat < 0) lat = c;
            if (out_valid_w && lat_w < 0) lat_w = c;
            if (lat >= 0 && lat_w >= 0) break;
        end
        check_eq("latency",   64'(lat),   64'd4);
        check_eq("latency_w", 64'(lat_w), 64'd1);
        check_eq("sum",         {32'd0, sum},            {32'd0, es});
        check_eq("carry_out",   {63'd0, carry_out},      {63'd0, eco});
        check_eq("overflow",    {63'd0, overflow},       {63'd0, eov});
        check_eq("zero",        {63'd0, zero},           {63'd0, ez});
        check_eq("sum_w",       {32'd0, sum_w},          {32'd0, es});
        check_eq("carry_out_w", {63'd0, carry_out_w},    {63'd0, eco});
        check_eq("overflow_w",  {63'd0, overflow_w},     {63'd0, eov});
        check_eq("zero_w",      {63'd0, zero_w},         {63'd0, ez});
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
            check_eq("hold_sum",       {32'd0, sum},       {32'd0, es});
            check_eq("hold_carry_out", {63'd0, carry_out}, {63'd0, eco});
            check_eq("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check_eq("hold_in_ready",  {63'd0, in_ready},  64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_in_ready",   {63'd0, in_ready},    64'd1);
        check_eq("post_out_valid",  {63'd0, out_valid},   64'd0);
        check_eq("post_in_ready_w", {63'd0, in_ready_w},  64'd1);
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        cur = "reset";
        check_eq("in_ready",  {63'd0, in_ready},  64'd1);
        check_eq("out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("sum",       {32'd0, sum},       64'd0);
        check_eq("carry_out", {63'd0, carry_out}, 64'd0);
        check_eq("overflow",  {63'd0, overflow},  64'd0);
        check_eq("zero",      {63'd0, zero},      64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add_ff_1",    32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 0);
        run_op("add_ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);
        run_op("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
        run_op("sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0);
        run_op("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0);
        run_op("sub_zero",    32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);
        run_op("backpress",   32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 5);
        // Issued right after the handshake: must be accepted with its own operands.
        run_op("after_bp",    32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 0);

        cur      = "abort";
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_0001;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("in_ready",    {63'd0, in_ready},    64'd1);
        check_eq("out_valid",   {63'd0, out_valid},   64'd0);
        check_eq("sum",         {32'd0, sum},         64'd0);
        check_eq("zero",        {63'd0, zero},        64'd0);
        check_eq("out_valid_w", {63'd0, out_valid_w}, 64'd0);
        check_eq("sum_w",       {32'd0, sum_w},       64'd0);
        seen = 0;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || out_valid_w) seen++;
        end
        out_ready = 1'b0;
        check_eq("no_result", 64'(seen), 64'd0);

        run_op("post_abort",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_add_sub.md
# seq_add_sub

Multi-cycle, parametrised adder/subtractor that processes WIDTH-bit operands in CHUNK-bit slices, least-significant slice first, with one slice per clock. The carry is held in a register between slices.

It succeeds the combinational ripple adder in the arithmetic datapath. Area scales with CHUNK rather than WIDTH, and it adds subtract mode, status flags and valid/ready handshakes on both sides. It sits between the operand register file and the ALU result mux, for wide or area-constrained operations.

## Interface
- WIDTH, 32: operand and result width. Must be a multiple of CHUNK, otherwise elaboration error.
- CHUNK, 8: slice width processed per cycle. CHUNK == WIDTH gives single-cycle compute.
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- sub  input  1  0: a+b; 1: a-b (two's complement).
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, mod 2^WIDTH.
- carry_out  output  1  final carry. For subtract, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

## Operation
- NCHUNK = WIDTH/CHUNK.
- States:
  - IDLE: in_ready=1.
  - RUN: chunk counter 0..NCHUNK-1.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid && in_ready:
  - register a and b XOR {WIDTH{sub}};
  - carry register = sub;
  - counter = 0.
- RUN, each cycle:
  - add the low CHUNK bits of the operand registers plus the carry register;
  - shift the result slice into the top of the sum register, which is a right-shift accumulator;
  - shift the operand registers right by CHUNK;
  - update the carry register;
  - increment the counter.
- On the last slice:
  - latch carry_out;
  - compute overflow from the MSB carry-in and carry-out of that slice;
  - go to DONE.
- DONE→IDLE on out_valid && out_ready.
- sum, carry_out, overflow and zero are registered. They are stable and held throughout DONE.
- zero is derived from the final sum register. It is meaningful only while out_valid=1.
- in_valid is ignored outside IDLE. Operands may change freely after acceptance.
- There is no pipelining: one operation in flight at a time.

## Timing
- Reset, sampled at a rising edge:
  - state=IDLE;
  - out_valid=0;
  - sum=0, carry_out=0, overflow=0, zero=0;
  - carry register and counter = 0.
- in_ready=1 from the first cycle after reset deasserts.
- Reset asserted mid-RUN or in DONE aborts the operation. No result is produced.
- Reset has priority over every handshake in the same cycle.
- Latency: accept at edge E0; slice k is registered at edge E0+k+1; out_valid rises after edge E0+NCHUNK.
- Minimum issue interval is NCHUNK+2 cycles: accept, NCHUNK RUN cycles, DONE handshake, return to IDLE.
- Backpressure: out_ready=0 holds DONE indefinitely, with outputs unchanged and in_ready=0.
- Carry propagates across slice boundaries through the register only. The combinational path is one CHUNK-bit slice.

## Structure
- Shared arithmetic package holds:
  - the state encoding constants IDLE/RUN/DONE;
  - a function for NCHUNK;
  - a function for counter width, clog2(NCHUNK) with minimum 1.
- One sub-module: chunk_adder.
  - Parametrised CHUNK-bit ripple slice.
  - Inputs a, b, ci. Outputs s, co, and c_msb (carry into the top bit), used for overflow.
- The top level contains the FSM, shift registers, carry register and flag logic.

## Test plan
All scenarios use WIDTH=32 and CHUNK=8 unless stated otherwise.
- a=0x000000FF, b=0x00000001, sub=0 → sum=0x00000100, carry_out=0, overflow=0, zero=0; out_valid exactly 4 cycles after accept.
- a=0xFFFFFFFF, b=0x00000001, sub=0 → sum=0, carry_out=1, zero=1, overflow=0. Checks carry ripple through all 4 slices.
- a=0x7FFFFFFF, b=0x00000001, sub=0 → sum=0x80000000, overflow=1, carry_out=0.
- sub=1:
  - a=5, b=7 → sum=0xFFFFFFFE, carry_out=0, overflow=0;
  - a=0x80000000, b=1 → sum=0x7FFFFFFF, carry_out=1, overflow=1.
- Backpressure:
  - hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands;
  - required: outputs stable, in_ready=0, new operands not taken;
  - release out_ready: handshake, then IDLE, and the next operation is accepted the following cycle.
- Reset and variant width:
  - assert reset at RUN slice 2 → next cycle IDLE, out_valid=0, sum=0, and no result is ever issued;
  - repeat scenario 2 with CHUNK=32 → out_valid 1 cycle after accept.
